// File: rtl/uart_fifo_core.sv
// rtl/uart_fifo_core.sv - UART transmitter/receiver with TX and RX FIFOs
module uart_fifo_core #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [15:0]          baud_div,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_wr,
  output logic                 tx_full,
  output logic                 tx_empty,
  output logic                 tx_busy,
  output logic                 uart_tx,
  input  logic                 uart_rx,
  output logic [DATA_BITS-1:0] rx_data,
  input  logic                 rx_rd,
  output logic                 rx_empty,
  output logic                 rx_full,
  output logic                 rx_overrun,
  input  logic                 rx_ovr_clr,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err
);

  localparam int         AW       = $clog2(FIFO_DEPTH);
  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);
  localparam logic       PAR_EN   = (PARITY_EN != 0);
  localparam logic       PAR_ODD  = (PARITY_ODD != 0);

  // Bit periods shorter than 4 clocks leave no room for a mid-bit sample.
  logic [15:0] baud_eff;
  assign baud_eff = (baud_div < 16'd4) ? 16'd4 : baud_div;

  // ---------------- TX FIFO ----------------
  logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
  logic [AW:0]          tx_wp_q, tx_rp_q;
  logic                 tx_push, tx_pop;
  logic [DATA_BITS-1:0] tx_head;

  assign tx_push  = tx_wr && !tx_full;
  assign tx_empty = (tx_wp_q == tx_rp_q);
  assign tx_full  = (tx_wp_q[AW] != tx_rp_q[AW]) && (tx_wp_q[AW-1:0] == tx_rp_q[AW-1:0]);
  assign tx_head  = tx_mem[tx_rp_q[AW-1:0]];

  // TX storage write; contents need no reset since pointers gate visibility
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp_q[AW-1:0]] <= tx_data;
  end

  // TX pointer update
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_wp_q <= '0;
      tx_rp_q <= '0;
    end else begin
      if (tx_push) tx_wp_q <= tx_wp_q + 1'b1;
      if (tx_pop)  tx_rp_q <= tx_rp_q + 1'b1;
    end
  end

  // ---------------- TX FSM ----------------
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  tx_state_t            tx_state_q;
  logic [15:0]          tx_cnt_q, tx_baud_q;
  logic [3:0]           tx_bit_q;
  logic [DATA_BITS-1:0] tx_shreg_q;
  logic                 tx_par_q, tx_line_q, tx_line_d, tx_bit_end;

  assign tx_bit_end = (tx_cnt_q == tx_baud_q - 16'd1);
  assign tx_pop     = !tx_empty && ((tx_state_q == TX_IDLE) || (tx_state_q == TX_STOP && tx_bit_end));
  assign tx_busy    = (tx_state_q != TX_IDLE);
  assign uart_tx    = tx_line_q;

  // Line level for the current state; registered one cycle later onto uart_tx
  always_comb begin
    tx_line_d = 1'b1;
    case (tx_state_q)
      TX_START:  tx_line_d = 1'b0;
      TX_DATA:   tx_line_d = tx_shreg_q[0];
      TX_PARITY: tx_line_d = tx_par_q;
      default:   tx_line_d = 1'b1;
    endcase
  end

  // TX sequencing: a pop in IDLE or at the end of STOP loads the next frame
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_baud_q  <= 16'd4;
      tx_bit_q   <= '0;
      tx_shreg_q <= '0;
      tx_par_q   <= 1'b0;
      tx_line_q  <= 1'b1;
    end else begin
      tx_line_q <= tx_line_d;
      if (tx_pop) begin
        tx_shreg_q <= tx_head;
        tx_par_q   <= (^tx_head) ^ PAR_ODD;
        tx_baud_q  <= baud_eff;
        tx_cnt_q   <= '0;
        tx_state_q <= TX_START;
      end else if (tx_state_q != TX_IDLE) begin
        if (tx_bit_end) begin
          tx_cnt_q <= '0;
          case (tx_state_q)
            TX_START: begin
              tx_bit_q   <= '0;
              tx_state_q <= TX_DATA;
            end
            TX_DATA: begin
              tx_shreg_q <= tx_shreg_q >> 1;
              tx_bit_q   <= tx_bit_q + 4'd1;
              if (tx_bit_q == LAST_BIT) tx_state_q <= PAR_EN ? TX_PARITY : TX_STOP;
            end
            TX_PARITY: tx_state_q <= TX_STOP;
            default:   tx_state_q <= TX_IDLE;
          endcase
        end else begin
          tx_cnt_q <= tx_cnt_q + 16'd1;
        end
      end
    end
  end

  // ---------------- RX synchronizer ----------------
  logic rx_meta_q, rx_sync_q, rx_prev_q;

  // Two-flop synchronizer plus a history flop for falling-edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= uart_rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // ---------------- RX FSM ----------------
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT} rx_state_t;
  rx_state_t            rx_state_q;
  logic [15:0]          rx_cnt_q, rx_baud_q;
  logic [3:0]           rx_bit_q;
  logic [DATA_BITS-1:0] rx_shreg_q;
  logic                 rx_ferr_q, rx_perr_q, rx_hit, rx_par_exp, rx_push;

  assign rx_hit = (rx_state_q == RX_START) ? (rx_cnt_q == (rx_baud_q >> 1) - 16'd1)
                                           : (rx_cnt_q == rx_baud_q - 16'd1);
  assign rx_par_exp    = (^rx_shreg_q) ^ PAR_ODD;
  assign rx_push       = (rx_state_q == RX_STOP) && rx_hit && rx_sync_q;
  assign rx_frame_err  = rx_ferr_q;
  assign rx_parity_err = rx_perr_q;

  // RX sequencing: half-bit to mid start, then one full bit per later sample
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_baud_q  <= 16'd4;
      rx_bit_q   <= '0;
      rx_shreg_q <= '0;
      rx_ferr_q  <= 1'b0;
      rx_perr_q  <= 1'b0;
    end else begin
      rx_ferr_q <= 1'b0;
      rx_perr_q <= 1'b0;
      case (rx_state_q)
        RX_IDLE: begin
          if (rx_prev_q && !rx_sync_q) begin
            rx_baud_q  <= baud_eff;
            rx_cnt_q   <= '0;
            rx_state_q <= RX_START;
          end
        end
        RX_WAIT: begin
          if (rx_sync_q) rx_state_q <= RX_IDLE;
        end
        default: begin
          if (!rx_hit) begin
            rx_cnt_q <= rx_cnt_q + 16'd1;
          end else begin
            rx_cnt_q <= '0;
            case (rx_state_q)
              RX_START: begin
                rx_bit_q   <= '0;
                rx_state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
              end
              RX_DATA: begin
                rx_shreg_q <= {rx_sync_q, rx_shreg_q[DATA_BITS-1:1]};
                rx_bit_q   <= rx_bit_q + 4'd1;
                if (rx_bit_q == LAST_BIT) rx_state_q <= PAR_EN ? RX_PARITY : RX_STOP;
              end
              RX_PARITY: begin
                if (rx_sync_q != rx_par_exp) begin
                  rx_perr_q  <= 1'b1;
                  rx_state_q <= RX_IDLE;
                end else begin
                  rx_state_q <= RX_STOP;
                end
              end
              default: begin
                if (!rx_sync_q) begin
                  rx_ferr_q  <= 1'b1;
                  rx_state_q <= RX_WAIT;
                end else begin
                  rx_state_q <= RX_IDLE;
                end
              end
            endcase
          end
        end
      endcase
    end
  end

  // ---------------- RX FIFO ----------------
  logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
  logic [AW:0]          rx_wp_q, rx_rp_q;
  logic                 rx_pop, rx_wr_ok, rx_ovr_q, rx_ovr_d;

  assign rx_pop     = rx_rd && !rx_empty;
  assign rx_wr_ok   = rx_push && (!rx_full || rx_pop);
  assign rx_empty   = (rx_wp_q == rx_rp_q);
  assign rx_full    = (rx_wp_q[AW] != rx_rp_q[AW]) && (rx_wp_q[AW-1:0] == rx_rp_q[AW-1:0]);
  assign rx_data    = rx_empty ? '0 : rx_mem[rx_rp_q[AW-1:0]];
  assign rx_overrun = rx_ovr_q;

  // Overrun is sticky; a new loss in the same cycle as a clear keeps it set
  always_comb begin
    rx_ovr_d = rx_ovr_q;
    if (rx_ovr_clr) rx_ovr_d = 1'b0;
    if (rx_push && rx_full && !rx_pop) rx_ovr_d = 1'b1;
  end

  // RX storage write
  always_ff @(posedge clk) begin
    if (rx_wr_ok) rx_mem[rx_wp_q[AW-1:0]] <= rx_shreg_q;
  end

  // RX pointer and overrun update
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_wp_q  <= '0;
      rx_rp_q  <= '0;
      rx_ovr_q <= 1'b0;
    end else begin
      if (rx_wr_ok) rx_wp_q <= rx_wp_q + 1'b1;
      if (rx_pop)   rx_rp_q <= rx_rp_q + 1'b1;
      rx_ovr_q <= rx_ovr_d;
    end
  end

endmodule

// File: tb/tb_uart_fifo_core.sv
// tb/tb_uart_fifo_core.sv - scoreboard bench for uart_fifo_core
module tb_uart_fifo_core;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] baud_div = 16'd16;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_wr = 1'b0, rx_rd = 1'b0, rx_ovr_clr = 1'b0;
  logic        rx_line = 1'b1, loop_en = 1'b0;
  logic        uart_rx;
  logic        tx_full, tx_empty, tx_busy, uart_tx;
  logic [7:0]  rx_data;
  logic        rx_empty, rx_full, rx_overrun, rx_frame_err, rx_parity_err;

  logic        rx_rd_p = 1'b0, rx_line_p = 1'b1;
  logic        p_tx_full, p_tx_empty, p_tx_busy, p_uart_tx;
  logic [7:0]  p_rx_data;
  logic        p_rx_empty, p_rx_full, p_rx_overrun, p_rx_frame_err, p_rx_parity_err;

  int errors = 0, checks = 0;
  int fe_cnt = 0, pe_cnt = 0, fe_p_cnt = 0, pe_p_cnt = 0;
  logic [7:0] sb[$];

  always #5 clk = ~clk;
  assign uart_rx = loop_en ? uart_tx : rx_line;

  uart_fifo_core #(.DATA_BITS(8), .FIFO_DEPTH(8), .PARITY_EN(0), .PARITY_ODD(0)) dut (
    .clk(clk), .reset(reset), .baud_div(baud_div), .tx_data(tx_data), .tx_wr(tx_wr),
    .tx_full(tx_full), .tx_empty(tx_empty), .tx_busy(tx_busy), .uart_tx(uart_tx),
    .uart_rx(uart_rx), .rx_data(rx_data), .rx_rd(rx_rd), .rx_empty(rx_empty),
    .rx_full(rx_full), .rx_overrun(rx_overrun), .rx_ovr_clr(rx_ovr_clr),
    .rx_frame_err(rx_frame_err), .rx_parity_err(rx_parity_err));

  uart_fifo_core #(.DATA_BITS(8), .FIFO_DEPTH(8), .PARITY_EN(1), .PARITY_ODD(0)) dut_p (
    .clk(clk), .reset(reset), .baud_div(baud_div), .tx_data(8'h00), .tx_wr(1'b0),
    .tx_full(p_tx_full), .tx_empty(p_tx_empty), .tx_busy(p_tx_busy), .uart_tx(p_uart_tx),
    .uart_rx(rx_line_p), .rx_data(p_rx_data), .rx_rd(rx_rd_p), .rx_empty(p_rx_empty),
    .rx_full(p_rx_full), .rx_overrun(p_rx_overrun), .rx_ovr_clr(1'b0),
    .rx_frame_err(p_rx_frame_err), .rx_parity_err(p_rx_parity_err));

  always @(negedge clk) begin
    if (rx_frame_err)    fe_cnt++;
    if (rx_parity_err)   pe_cnt++;
    if (p_rx_frame_err)  fe_p_cnt++;
    if (p_rx_parity_err) pe_p_cnt++;
  end

  task automatic drive_frame(input bit to_p, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      if (to_p) rx_line_p = bits[i]; else rx_line = bits[i];
      repeat (16) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (uart_tx !== 1'b1)    begin errors++; $display("FAIL reset_uart_tx got=%b exp=1", uart_tx); end
    checks++; if (tx_busy !== 1'b0)    begin errors++; $display("FAIL reset_tx_busy got=%b exp=0", tx_busy); end
    checks++; if (tx_empty !== 1'b1)   begin errors++; $display("FAIL reset_tx_empty got=%b exp=1", tx_empty); end
    checks++; if (tx_full !== 1'b0)    begin errors++; $display("FAIL reset_tx_full got=%b exp=0", tx_full); end
    checks++; if (rx_empty !== 1'b1)   begin errors++; $display("FAIL reset_rx_empty got=%b exp=1", rx_empty); end
    checks++; if (rx_full !== 1'b0)    begin errors++; $display("FAIL reset_rx_full got=%b exp=0", rx_full); end
    checks++; if (rx_overrun !== 1'b0) begin errors++; $display("FAIL reset_rx_overrun got=%b exp=0", rx_overrun); end
    checks++; if ({rx_frame_err, rx_parity_err} !== 2'b00) begin errors++; $display("FAIL reset_err_pulses got=%b exp=00", {rx_frame_err, rx_parity_err}); end
    checks++; if (rx_data !== 8'h00)   begin errors++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_tx_frame();
    logic       line [180];
    logic [9:0] fr;
    logic       ok;
    int         busy;
    busy = 0;
    fr = {1'b1, 8'h55, 1'b0};
    loop_en = 1'b0; baud_div = 16'd16;
    tx_data = 8'h55; tx_wr = 1'b1;
    for (int i = 0; i < 180; i++) begin
      @(negedge clk);
      tx_wr = 1'b0;
      line[i] = uart_tx;
      if (tx_busy) busy++;
    end
    checks++; if (line[1] !== 1'b1) begin errors++; $display("FAIL tx_edge1 got=%b exp=1", line[1]); end
    checks++; if (line[2] !== 1'b0) begin errors++; $display("FAIL tx_edge2_start got=%b exp=0", line[2]); end
    for (int k = 0; k < 10; k++) begin
      ok = 1'b1;
      for (int j = 0; j < 16; j++) if (line[2 + 16*k + j] !== fr[k]) ok = 1'b0;
      checks++; if (!ok) begin errors++; $display("FAIL tx_bit%0d got=not-constant-%b exp=%b", k, fr[k], fr[k]); end
    end
    ok = 1'b1;
    for (int i = 162; i < 180; i++) if (line[i] !== 1'b1) ok = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL tx_idle_after got=low exp=high"); end
    checks++; if (busy != 160) begin errors++; $display("FAIL tx_busy_cycles got=%0d exp=160", busy); end
  endtask

  task automatic test_loopback();
    logic [7:0] bytes [3];
    logic [7:0] exp;
    int run, maxrun, got;
    bytes = '{8'h00, 8'hFF, 8'hA5};
    run = 0; maxrun = 0; got = 0; fe_cnt = 0; pe_cnt = 0;
    loop_en = 1'b1; baud_div = 16'd16;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      rx_rd = 1'b0;
      if (tx_busy) run++; else begin if (run > maxrun) maxrun = run; run = 0; end
      if (cyc < 3) begin tx_data = bytes[cyc]; tx_wr = 1'b1; sb.push_back(bytes[cyc]); end
      else tx_wr = 1'b0;
      if (!rx_empty) begin
        if (sb.size() == 0) begin
          checks++; errors++; $display("FAIL loop_extra_byte got=%h exp=none", rx_data);
        end else begin
          exp = sb.pop_front();
          checks++; if (rx_data !== exp) begin errors++; $display("FAIL loop_rx_data got=%h exp=%h", rx_data, exp); end
        end
        got++; rx_rd = 1'b1;
      end
      if (cyc > 3 && got >= 3 && !tx_busy) break;
    end
    @(negedge clk); rx_rd = 1'b0;
    if (run > maxrun) maxrun = run;
    checks++; if (got != 3) begin errors++; $display("FAIL loop_count got=%0d exp=3", got); end
    checks++; if (maxrun != 480) begin errors++; $display("FAIL loop_no_gap busy_run got=%0d exp=480", maxrun); end
    checks++; if (fe_cnt + pe_cnt != 0) begin errors++; $display("FAIL loop_err_pulses got=%0d exp=0", fe_cnt + pe_cnt); end
  endtask

  task automatic test_overrun();
    logic [7:0] b, exp;
    int run, maxrun;
    run = 0; maxrun = 0; fe_cnt = 0; pe_cnt = 0;
    sb.delete();
    loop_en = 1'b1; baud_div = 16'd1;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      @(negedge clk);
      if (tx_busy) run++; else begin if (run > maxrun) maxrun = run; run = 0; end
      if (cyc == 9) begin
        checks++; if (tx_full !== 1'b1) begin errors++; $display("FAIL tx_full got=%b exp=1", tx_full); end
      end
      if (cyc < 9) begin
        b = 8'($urandom_range(0, 255));
        tx_data = b; tx_wr = 1'b1;
        if (cyc < 8) sb.push_back(b);
      end else tx_wr = 1'b0;
      if (cyc > 9 && !tx_busy) break;
    end
    repeat (30) @(negedge clk);
    checks++; if (maxrun != 360) begin errors++; $display("FAIL ovr_baud_clamp busy_run got=%0d exp=360", maxrun); end
    checks++; if (rx_full !== 1'b1)    begin errors++; $display("FAIL ovr_rx_full got=%b exp=1", rx_full); end
    checks++; if (rx_overrun !== 1'b1) begin errors++; $display("FAIL ovr_set got=%b exp=1", rx_overrun); end
    for (int k = 0; k < 8; k++) begin
      exp = sb.pop_front();
      checks++; if (rx_empty !== 1'b0 || rx_data !== exp) begin errors++; $display("FAIL ovr_data%0d got=%h empty=%b exp=%h", k, rx_data, rx_empty, exp); end
      rx_rd = 1'b1;
      @(negedge clk);
      rx_rd = 1'b0;
    end
    checks++; if (rx_empty !== 1'b1)   begin errors++; $display("FAIL ovr_drained got=%b exp=1", rx_empty); end
    checks++; if (rx_overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got=%b exp=1", rx_overrun); end
    rx_rd = 1'b1;
    @(negedge clk);
    rx_rd = 1'b0;
    checks++; if (rx_empty !== 1'b1 || rx_full !== 1'b0) begin errors++; $display("FAIL rd_when_empty got=empty%b full%b exp=empty1 full0", rx_empty, rx_full); end
    rx_ovr_clr = 1'b1;
    @(negedge clk);
    rx_ovr_clr = 1'b0;
    checks++; if (rx_overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear got=%b exp=0", rx_overrun); end
    checks++; if (fe_cnt + pe_cnt != 0) begin errors++; $display("FAIL ovr_err_pulses got=%0d exp=0", fe_cnt + pe_cnt); end
    baud_div = 16'd16;
  endtask

  task automatic test_frame_err();
    logic [7:0] exp;
    loop_en = 1'b0; baud_div = 16'd16; fe_cnt = 0; pe_cnt = 0;
    drive_frame(1'b0, {6'd0, 1'b0, 8'h3C, 1'b0}, 10);
    drive_frame(1'b0, 16'h0000, 1);
    rx_line = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if (fe_cnt != 1) begin errors++; $display("FAIL frame_err_pulses got=%0d exp=1", fe_cnt); end
    checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL frame_err_dropped got=%b exp=1", rx_empty); end
    fe_cnt = 0;
    rx_line = 1'b0;
    repeat (3) @(negedge clk);
    rx_line = 1'b1;
    repeat (40) @(negedge clk);
    checks++; if (fe_cnt + pe_cnt != 0 || rx_empty !== 1'b1) begin errors++; $display("FAIL glitch got=err%0d empty%b exp=err0 empty1", fe_cnt + pe_cnt, rx_empty); end
    sb.push_back(8'h3C);
    drive_frame(1'b0, {6'd0, 1'b1, 8'h3C, 1'b0}, 10);
    repeat (20) @(negedge clk);
    exp = sb.pop_front();
    checks++; if (rx_empty !== 1'b0 || rx_data !== exp) begin errors++; $display("FAIL rearm_rx got=%h empty=%b exp=%h", rx_data, rx_empty, exp); end
    rx_rd = 1'b1; @(negedge clk); rx_rd = 1'b0;
  endtask

  task automatic test_parity();
    logic [7:0] exp;
    baud_div = 16'd16; pe_p_cnt = 0; fe_p_cnt = 0;
    drive_frame(1'b1, {5'd0, 1'b1, 1'b0, 8'h07, 1'b0}, 11);
    repeat (20) @(negedge clk);
    checks++; if (pe_p_cnt != 1) begin errors++; $display("FAIL parity_err_pulse got=%0d exp=1", pe_p_cnt); end
    checks++; if (p_rx_empty !== 1'b1) begin errors++; $display("FAIL parity_dropped got=%b exp=1", p_rx_empty); end
    pe_p_cnt = 0;
    sb.push_back(8'h07);
    drive_frame(1'b1, {5'd0, 1'b1, 1'b1, 8'h07, 1'b0}, 11);
    repeat (20) @(negedge clk);
    exp = sb.pop_front();
    checks++; if (p_rx_empty !== 1'b0 || p_rx_data !== exp) begin errors++; $display("FAIL parity_good_rx got=%h empty=%b exp=%h", p_rx_data, p_rx_empty, exp); end
    checks++; if (pe_p_cnt + fe_p_cnt != 0) begin errors++; $display("FAIL parity_good_err got=%0d exp=0", pe_p_cnt + fe_p_cnt); end
    rx_rd_p = 1'b1; @(negedge clk); rx_rd_p = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp;
    int got;
    got = 0;
    loop_en = 1'b1; baud_div = 16'd16;
    tx_data = 8'h5A; tx_wr = 1'b1;
    @(negedge clk); tx_wr = 1'b0;
    repeat (60) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (uart_tx !== 1'b1 || tx_busy !== 1'b0) begin errors++; $display("FAIL midrst_tx got=tx%b busy%b exp=tx1 busy0", uart_tx, tx_busy); end
    checks++; if (tx_empty !== 1'b1 || rx_empty !== 1'b1 || rx_overrun !== 1'b0) begin errors++; $display("FAIL midrst_flags got=txe%b rxe%b ovr%b exp=1 1 0", tx_empty, rx_empty, rx_overrun); end
    @(negedge clk);
    reset = 1'b0;
    fe_cnt = 0; pe_cnt = 0;
    repeat (200) @(negedge clk);
    checks++; if (rx_empty !== 1'b1 || fe_cnt + pe_cnt != 0) begin errors++; $display("FAIL midrst_no_partial got=empty%b err%0d exp=empty1 err0", rx_empty, fe_cnt + pe_cnt); end
    tx_data = 8'hC3; tx_wr = 1'b1; sb.push_back(8'hC3);
    @(negedge clk); tx_wr = 1'b0;
    for (int cyc = 0; cyc < 400 && got == 0; cyc++) begin
      @(negedge clk);
      if (!rx_empty) begin
        exp = sb.pop_front();
        checks++; if (rx_data !== exp) begin errors++; $display("FAIL midrst_next_rx got=%h exp=%h", rx_data, exp); end
        got = 1;
      end
    end
    checks++; if (got != 1) begin errors++; $display("FAIL midrst_timeout got=%0d exp=1", got); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_tx_frame();
    test_loopback();
    test_overrun();
    test_frame_err();
    test_parity();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
